// File: rtl/aes_round_sequencer.sv
// Iterative AES encrypt controller: one initial AddRoundKey, then NR launches of an external clocked round unit.
// Latency: out_valid rises NR*(LAT+1) clk edges after the accepting edge; the next block is accepted 2 edges after that at the earliest.
// Backpressure: in_ready is low whenever busy; ciphertext is held in DONE until out_ready, and nothing new is accepted meanwhile.
module aes_round_sequencer #(
    parameter  int NR  = 10,
    parameter  int LAT = 1,
    localparam int KW  = $clog2(NR + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [127:0]  in_block,
    input  logic          key_ready,
    output logic [KW-1:0] key_idx,
    input  logic [127:0]  key_word,
    output logic [127:0]  rnd_state,
    output logic [127:0]  rnd_key,
    output logic          rnd_final,
    input  logic [127:0]  rnd_result,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  out_block,
    output logic          busy
);

    // Wait counter only has to reach LAT, so size it for that.
    localparam int WW = $clog2(LAT + 1);

    localparam logic [KW-1:0] R_LAST  = KW'(NR);
    localparam logic [KW-1:0] R_FIRST = KW'(1);
    localparam logic [WW-1:0] W_LAST  = WW'(LAT);
    localparam logic [WW-1:0] W_ONE   = WW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [KW-1:0]  r_q, r_d;          // round being executed, 1..NR
    logic [WW-1:0]  w_q, w_d;          // cycles spent in the current round
    logic [127:0]   sreg_q, sreg_d;    // AES state between rounds
    logic           ovld_q, ovld_d;
    logic [127:0]   oblk_q, oblk_d;

    logic           accept;
    logic           round_end;
    logic           last_round;

    // Acceptance is gated only by key_ready and being idle; key_ready is
    // deliberately ignored once a block is in flight.
    assign in_ready   = (state_q == IDLE) && key_ready;
    assign accept     = in_valid && in_ready;

    // The round unit is clocked, so its inputs come straight from registers
    // and stay put for all LAT+1 cycles of a round.
    assign last_round = (r_q == R_LAST);
    assign round_end  = (w_q == W_LAST);
    assign key_idx    = (state_q == RUN) ? r_q : '0;
    assign rnd_state  = sreg_q;
    assign rnd_key    = key_word;
    assign rnd_final  = (state_q == RUN) && last_round;

    assign out_valid  = ovld_q;
    assign out_block  = oblk_q;
    assign busy       = (state_q != IDLE);

    // State and datapath registers; reset abandons any partial result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            w_q     <= '0;
            sreg_q  <= '0;
            ovld_q  <= 1'b0;
            oblk_q  <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            w_q     <= w_d;
            sreg_q  <= sreg_d;
            ovld_q  <= ovld_d;
            oblk_q  <= oblk_d;
        end
    end

    // Next-state logic: launch/wait per round, hold the result until taken.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        w_d     = w_q;
        sreg_d  = sreg_q;
        ovld_d  = ovld_q;
        oblk_d  = oblk_q;

        case (state_q)
            IDLE: begin
                // key_idx is 0 here, so key_word is round key 0: the initial
                // AddRoundKey is folded into the accept.
                if (accept) begin
                    sreg_d  = in_block ^ key_word;
                    r_d     = R_FIRST;
                    w_d     = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                // rnd_result is only meaningful LAT cycles after launch;
                // earlier cycles carry stale pipeline contents.
                if (round_end) begin
                    sreg_d = rnd_result;
                    w_d    = '0;
                    if (last_round) begin
                        oblk_d  = rnd_result;
                        ovld_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        r_d = r_q + R_FIRST;
                    end
                end else begin
                    w_d = w_q + W_ONE;
                end
            end

            DONE: begin
                // Returning to IDLE only after the handshake edge means
                // in_ready can never rise in the handshake cycle itself.
                if (out_ready) begin
                    ovld_d  = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: software AES round unit and key store around two instances (LAT=1 and LAT=3).
// Latency: checked against NR*(LAT+1) edges from the accepting edge.
// Backpressure: out_ready is held low in one scenario and the held ciphertext is checked every cycle.
module tb_aes_round_sequencer;

    localparam int NR   = 10;
    localparam int LAT  = 1;
    localparam int LAT3 = 3;
    localparam int KW   = $clog2(NR + 1);

    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEYB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PTB  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CTB  = 128'h3925841d02dc09fbdc118597196a0b32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          key_ready;

    logic          in_valid, in_ready, out_valid, out_ready, rnd_final, busy;
    logic [127:0]  in_block, key_word, rnd_state, rnd_key, rnd_result, out_block;
    logic [KW-1:0] key_idx;

    logic          in_valid3, in_ready3, out_valid3, rnd_final3, busy3;
    logic [127:0]  in_block3, key_word3, rnd_state3, rnd_key3, rnd_result3, out_block3;
    logic [KW-1:0] key_idx3;
    logic          out_ready3 = 1'b1;

    logic [7:0]    sb [0:255];
    logic [127:0]  rk [0:15];
    logic [127:0]  exp_q [$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int acc_cyc = 0;
    logic prev_ov = 1'b0;

    aes_round_sequencer #(.NR(NR), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
        .key_ready(key_ready), .key_idx(key_idx), .key_word(key_word),
        .rnd_state(rnd_state), .rnd_key(rnd_key), .rnd_final(rnd_final),
        .rnd_result(rnd_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
        .busy(busy)
    );

    aes_round_sequencer #(.NR(NR), .LAT(LAT3)) dut3 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_block(in_block3),
        .key_ready(key_ready), .key_idx(key_idx3), .key_word(key_word3),
        .rnd_state(rnd_state3), .rnd_key(rnd_key3), .rnd_final(rnd_final3),
        .rnd_result(rnd_result3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_block(out_block3),
        .busy(busy3)
    );

    // ---------------- AES reference pieces ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k, input logic fin);
        logic [7:0]   a [0:15];
        logic [7:0]   b [0:15];
        logic [7:0]   c0, c1, c2, c3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) a[i] = sb[s[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                b[4*c+r] = a[4*((c+r)%4)+r];
        if (!fin) begin
            for (int c = 0; c < 4; c++) begin
                c0 = b[4*c]; c1 = b[4*c+1]; c2 = b[4*c+2]; c3 = b[4*c+3];
                b[4*c]   = xt(c0) ^ xt(c1) ^ c1 ^ c2 ^ c3;
                b[4*c+1] = c0 ^ xt(c1) ^ xt(c2) ^ c2 ^ c3;
                b[4*c+2] = c0 ^ c1 ^ xt(c2) ^ xt(c3) ^ c3;
                b[4*c+3] = xt(c0) ^ c0 ^ c1 ^ c2 ^ xt(c3);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
        return o ^ k;
    endfunction

    function automatic logic [127:0] ref_enc(input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ rk[0];
        for (int r = 1; r <= NR; r++) s = aes_round(s, rk[r], r == NR);
        return s;
    endfunction

    task automatic load_key(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= NR; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        for (int r = NR + 1; r < 16; r++) rk[r] = '0;
    endtask

    // ---------------- environment models ----------------
    assign key_word  = rk[key_idx];
    assign key_word3 = rk[key_idx3];

    logic [127:0] dp1;
    logic [127:0] dp3 [0:2];

    // Clocked round unit, one register stage.
    always @(posedge clk) dp1 <= aes_round(rnd_state, rnd_key, rnd_final);
    assign rnd_result = dp1;

    // Clocked round unit, three register stages.
    always @(posedge clk) begin
        dp3[0] <= aes_round(rnd_state3, rnd_key3, rnd_final3);
        dp3[1] <= dp3[0];
        dp3[2] <= dp3[1];
    end
    assign rnd_result3 = dp3[2];

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, want);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    // Monitor: pops the scoreboard on every output handshake and checks
    // the first-visible latency of each result.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && !prev_ov)
                chk("latency", 128'(cyc - acc_cyc), 128'(NR * (LAT + 1)));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) fail_now("spurious_output");
                else chk("ciphertext", out_block, exp_q.pop_front());
            end
        end
        prev_ov <= out_valid;
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [127:0] blk, input logic [127:0] want, output int waited);
        in_valid = 1'b1;
        in_block = blk;
        waited   = 0;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (in_ready) begin
            exp_q.push_back(want);
            acc_cyc = cyc + 1;
        end else begin
            fail_now("accept_timeout");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_block = ~blk;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || busy) fail_now("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    initial begin
        int waited;
        int prev_acc;
        int n;
        logic [127:0] b2b [0:7];

        b2b[0] = 128'h0123456789abcdeffedcba9876543210;
        b2b[1] = 128'h00000000000000000000000000000000;
        b2b[2] = 128'hffffffffffffffffffffffffffffffff;
        b2b[3] = 128'h80000000000000000000000000000001;
        b2b[4] = 128'hdeadbeefcafef00d0badc0de12345678;
        b2b[5] = 128'h5a5a5a5aa5a5a5a53c3c3c3cc3c3c3c3;
        b2b[6] = 128'h13579bdf2468ace0fdb97531eca86420;
        b2b[7] = 128'h00112233445566778899aabbccddeef0;

        for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));
        load_key(KEY1);

        rst = 1'b1; key_ready = 1'b1; out_ready = 1'b1;
        in_valid = 1'b0; in_block = '0; in_valid3 = 1'b0; in_block3 = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",      128'(busy),      128'(0));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_block", out_block,       128'(0));
        chk("rst_key_idx",   128'(key_idx),   128'(0));
        chk("rst_rnd_final", 128'(rnd_final), 128'(0));
        chk("rst_in_ready",  128'(in_ready),  128'(1));
        chk("rst_busy3",     128'(busy3),     128'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // FIPS-197 C.1 and appendix B known answers (latency checked by monitor)
        send(PT1, CT1, waited);
        drain();
        load_key(KEYB);
        send(PTB, CTB, waited);
        drain();
        load_key(KEY1);

        // Backpressure: result held for 50 cycles, then exactly one handshake
        out_ready = 1'b0;
        send(PT1, CT1, waited);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) fail_now("bp_wait_valid");
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 128'(out_valid), 128'(1));
            chk("bp_out_block", out_block,       CT1);
            chk("bp_in_ready",  128'(in_ready),  128'(0));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_no_turnaround", 128'(in_ready), 128'(0));
        @(negedge clk);
        chk("bp_after_valid", 128'(out_valid), 128'(0));
        chk("bp_after_busy",  128'(busy),      128'(0));
        chk("bp_after_ready", 128'(in_ready),  128'(1));
        @(posedge clk); #1;

        // key_ready gating; key_ready dropping mid-run is ignored
        key_ready = 1'b0;
        in_valid  = 1'b1;
        in_block  = PT1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("kr_in_ready", 128'(in_ready), 128'(0));
            chk("kr_busy",     128'(busy),     128'(0));
        end
        @(posedge clk); #1;
        key_ready = 1'b1;
        send(PT1, CT1, waited);
        chk("kr_accept_wait", 128'(waited), 128'(0));
        key_ready = 1'b0;
        drain();
        key_ready = 1'b1;

        // Reset during round 5, then a clean encryption
        send(PT1, CT1, waited);
        n = 0;
        @(negedge clk);
        while (key_idx != KW'(5) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (key_idx != KW'(5)) fail_now("mid_rst_wait_round5");
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("mid_rst_busy",      128'(busy),      128'(0));
        chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
        chk("mid_rst_key_idx",   128'(key_idx),   128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        send(PT1, CT1, waited);
        drain();

        // Back-to-back with in_valid and out_ready both held high
        prev_acc = 0;
        for (int i = 0; i < 8; i++) begin
            send(b2b[i], ref_enc(b2b[i]), waited);
            if (i > 0) chk("b2b_gap", 128'(acc_cyc - prev_acc), 128'(NR * (LAT + 1) + 2));
            prev_acc = acc_cyc;
        end
        drain();

        // LAT=3 instance: latency and known answer
        in_valid3 = 1'b1;
        in_block3 = PT1;
        n = 0;
        @(negedge clk);
        while (!in_ready3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready3) fail_now("lat3_accept");
        n = cyc + 1;
        @(posedge clk); #1;
        in_valid3 = 1'b0;
        in_block3 = ~PT1;
        waited = 0;
        @(negedge clk);
        while (!out_valid3 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!out_valid3) fail_now("lat3_wait_valid");
        chk("lat3_latency", 128'(cyc - n), 128'(NR * (LAT3 + 1)));
        chk("lat3_ciphertext", out_block3, CT1);
        @(negedge clk);
        chk("lat3_idle", 128'(busy3), 128'(0));

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
